// File: rtl/vga_timing_pkg.sv
// Shared VGA timing header: 640x480@60 constants, derived totals/widths,
// and the helpers that classify a counter value into its blanking segment.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_SYNC_POL = 1'b0;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_HW      = $clog2(VGA_H_TOTAL);
    localparam int VGA_VW      = $clog2(VGA_V_TOTAL);

    typedef enum logic [1:0] {
        SEG_ACTIVE = 2'd0,
        SEG_FP     = 2'd1,
        SEG_SYNC   = 2'd2,
        SEG_BP     = 2'd3
    } axis_seg_e;

    // Counter width for a given total; a degenerate total of 1 still needs one bit.
    function automatic int axis_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    function automatic axis_seg_e axis_seg(input int cnt, input int active,
                                           input int fp, input int sync);
        if (cnt < active)
            return SEG_ACTIVE;
        else if (cnt < active + fp)
            return SEG_FP;
        else if (cnt < active + fp + sync)
            return SEG_SYNC;
        else
            return SEG_BP;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): wrapping counter plus sync and
// active flags decoded from the next count so they align with the count register.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter bit POL    = VGA_SYNC_POL
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       advance,
    output logic [axis_width(ACTIVE+FP+SYNC+BP)-1:0]   cnt_next,
    output logic                                       wrap,
    output logic [axis_width(ACTIVE+FP+SYNC+BP)-1:0]   cnt,
    output logic                                       sync,
    output logic                                       active
);

    localparam int            TOTAL = ACTIVE + FP + SYNC + BP;
    localparam int            W     = axis_width(TOTAL);
    localparam logic [W-1:0]  LAST  = W'(TOTAL - 1);

    logic      at_last;
    axis_seg_e seg_next;

    always_comb begin
        at_last  = (cnt == LAST);
        wrap     = advance && at_last;
        cnt_next = cnt;
        if (advance)
            cnt_next = at_last ? '0 : cnt + W'(1);
        seg_next = axis_seg(int'(cnt_next), ACTIVE, FP, SYNC);
    end

    // Reset parks the count on the last position so the first advance lands on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= LAST;
            sync   <= ~POL;
            active <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            sync   <= (seg_next == SEG_SYNC) ? POL : ~POL;
            active <= (seg_next == SEG_ACTIVE);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Pixel-rate VGA timing generator: chains a horizontal and a vertical axis
// counter and produces display enable plus line/frame start pulses.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = VGA_SYNC_POL
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                pix_en,
    output logic                                                hsync,
    output logic                                                vsync,
    output logic                                                de,
    output logic [axis_width(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]    x,
    output logic [axis_width(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]    y,
    output logic                                                line_start,
    output logic                                                frame_start
);

    localparam int HW = axis_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW = axis_width(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    logic          h_wrap;
    logic          v_wrap;
    logic          h_active;
    logic          v_active;

    logic          line_start_reg;
    logic          line_start_next;
    logic          frame_start_reg;
    logic          frame_start_next;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (SYNC_POL)
    ) u_h_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (pix_en),
        .cnt_next (h_next),
        .wrap     (h_wrap),
        .cnt      (x),
        .sync     (hsync),
        .active   (h_active)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (SYNC_POL)
    ) u_v_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (h_wrap),
        .cnt_next (v_next),
        .wrap     (v_wrap),
        .cnt      (y),
        .sync     (vsync),
        .active   (v_active)
    );

    // Next counts serve top-levels that prefetch pixels ahead of x/y.
    logic unused_next;
    assign unused_next = ^{h_next, v_next};

    assign de = h_active & v_active;

    // v_wrap already implies an h wrap, so it marks the step onto (0,0).
    always_comb begin
        line_start_next  = h_wrap;
        frame_start_next = v_wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: three timing configurations driven by directed and
// random pix_en, each checked against a linear-position reference model.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] pe;

    always #5 clk = ~clk;

    logic       hs0, vs0, de0, ls0, fs0;
    logic [9:0] x0;
    logic [9:0] y0;
    logic       hs1, vs1, de1, ls1, fs1;
    logic [5:0] x1;
    logic [4:0] y1;
    logic       hs2, vs2, de2, ls2, fs2;
    logic [3:0] x2;
    logic [2:0] y2;

    vga_sync_gen dut0 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe[0]),
        .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
        .line_start(ls0), .frame_start(fs0)
    );

    vga_sync_gen #(
        .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2), .SYNC_POL(1'b0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe[1]),
        .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
        .line_start(ls1), .frame_start(fs1)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe[2]),
        .hsync(hs2), .vsync(vs2), .de(de2), .x(x2), .y(y2),
        .line_start(ls2), .frame_start(fs2)
    );

    logic [31:0] ox [3];
    logic [31:0] oy [3];
    logic        ohs [3];
    logic        ovs [3];
    logic        ode [3];
    logic        ols [3];
    logic        ofs [3];

    assign ox[0] = 32'(x0);  assign oy[0] = 32'(y0);
    assign ox[1] = 32'(x1);  assign oy[1] = 32'(y1);
    assign ox[2] = 32'(x2);  assign oy[2] = 32'(y2);
    assign ohs[0] = hs0; assign ovs[0] = vs0; assign ode[0] = de0; assign ols[0] = ls0; assign ofs[0] = fs0;
    assign ohs[1] = hs1; assign ovs[1] = vs1; assign ode[1] = de1; assign ols[1] = ls1; assign ofs[1] = fs1;
    assign ohs[2] = hs2; assign ovs[2] = vs2; assign ode[2] = de2; assign ols[2] = ls2; assign ofs[2] = fs2;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit pol;
    } cfg_t;

    function automatic cfg_t cfg(input int i);
        cfg_t c;
        case (i)
            0:       c = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, pol:1'b0};
            1:       c = '{ha:20,  hf:4,  hs:6,  hb:4,  va:10,  vf:2,  vs:3, vb:2,  pol:1'b0};
            default: c = '{ha:8,   hf:2,  hs:2,  hb:2,  va:4,   vf:1,  vs:1, vb:1,  pol:1'b1};
        endcase
        return c;
    endfunction

    // Reference: position kept as a pixel index into the frame.
    int mx [3];
    int my [3];
    bit mls [3];
    bit mfs [3];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            cfg_t c = cfg(i);
            mx[i]  = c.ha + c.hf + c.hs + c.hb - 1;
            my[i]  = c.va + c.vf + c.vs + c.vb - 1;
            mls[i] = 1'b0;
            mfs[i] = 1'b0;
        end
    endtask

    task automatic model_adv(input logic [2:0] en);
        for (int i = 0; i < 3; i++) begin
            cfg_t c = cfg(i);
            int ht = c.ha + c.hf + c.hs + c.hb;
            int vt = c.va + c.vf + c.vs + c.vb;
            if (en[i]) begin
                int p = (my[i] * ht + mx[i] + 1) % (ht * vt);
                mx[i]  = p % ht;
                my[i]  = p / ht;
                mls[i] = (mx[i] == 0);
                mfs[i] = (p == 0);
            end else begin
                mls[i] = 1'b0;
                mfs[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            cfg_t c = cfg(i);
            bit hs_on = (mx[i] >= c.ha + c.hf) && (mx[i] < c.ha + c.hf + c.hs);
            bit vs_on = (my[i] >= c.va + c.vf) && (my[i] < c.va + c.vf + c.vs);
            bit de_on = (mx[i] < c.ha) && (my[i] < c.va);
            chk("x", i, ox[i], 32'(mx[i]));
            chk("y", i, oy[i], 32'(my[i]));
            chk("hsync", i, 32'(ohs[i]), 32'(hs_on ? c.pol : !c.pol));
            chk("vsync", i, 32'(ovs[i]), 32'(vs_on ? c.pol : !c.pol));
            chk("de", i, 32'(ode[i]), 32'(de_on));
            chk("line_start", i, 32'(ols[i]), 32'(mls[i]));
            chk("frame_start", i, 32'(ofs[i]), 32'(mfs[i]));
        end
    endtask

    task automatic step(input logic [2:0] en);
        pe = en;
        @(posedge clk);
        if (rst_n)
            model_adv(en);
        #1;
        check_all();
    endtask

    initial begin
        int n;
        int dcnt;

        rst_n = 1'b0;
        pe    = 3'b000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        step(3'b111);
        step(3'b111);
        $display("phase reset_hold checks=%0d failures=%0d", checks, failures);

        rst_n = 1'b1;
        step(3'b111);
        $display("phase first_edge x0=%0d y0=%0d fs0=%0d ls0=%0d", x0, y0, fs0, ls0);

        // Line period on the default timing.
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            step(3'b111);
            n++;
            if (ls0) break;
        end
        chk("line_period", 0, 32'(n), 32'd800);
        $display("phase line_period n=%0d", n);

        repeat (1700) step(3'b111);
        $display("phase run_lines checks=%0d failures=%0d", checks, failures);

        for (int k = 0; k < 4000; k++)
            step((k % 4 == 0) ? 3'b111 : 3'b000);
        $display("phase pix_en_quarter checks=%0d failures=%0d", checks, failures);

        repeat (20000) step(3'($urandom));
        $display("phase random_pix_en checks=%0d failures=%0d", checks, failures);

        // Asynchronous reset mid-line, with no clock edge in between.
        for (int k = 0; k < 2000 && mx[0] != 300; k++)
            step(3'b111);
        chk("seek_x300", 0, ox[0], 32'd300);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (3) step(3'($urandom));
        rst_n = 1'b1;
        step(3'b000);
        step(3'b111);
        $display("phase async_reset x0=%0d y0=%0d fs0=%0d", x0, y0, fs0);

        // Small config: frame period and visible pixel count.
        for (int k = 0; k < 200 && !fs2; k++)
            step(3'b111);
        chk("frame_start_seen", 2, 32'(fs2), 32'd1);
        dcnt = ode[2] ? 1 : 0;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            step(3'b111);
            n++;
            if (fs2) break;
            if (ode[2]) dcnt++;
        end
        chk("frame_period", 2, 32'(n), 32'd98);
        chk("de_per_frame", 2, 32'(dcnt), 32'd32);
        $display("phase small_frame period=%0d de=%0d", n, dcnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
